// File: rtl/dlx_pkg.sv
// Shared DLX decode constants: opcodes, R-type funct codes, ALU operation
// encodings and the ID/EX control bundle. The execute stage imports this too.
package dlx_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int PC_W   = 10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  // Branches and jumps resolve in ID, so they carry no EX/MEM/WB control.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   c.alu_op = ALU_ADD;
          F_SUB:   c.alu_op = ALU_SUB;
          F_AND:   c.alu_op = ALU_AND;
          F_OR:    c.alu_op = ALU_OR;
          F_SLT:   c.alu_op = ALU_SLT;
          default: c.alu_op = ALU_NOP;
        endcase
        c.reg_write = (c.alu_op != ALU_NOP);
        c.reg_dst   = (c.alu_op != ALU_NOP);
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two combinational read ports and one write port.
// Reads of the register being written this cycle see the write data.
module register_file
  import dlx_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] i_ra_addr,
  input  logic [REG_AW-1:0] i_rb_addr,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data
);

  logic [DATA_W-1:0] r_regs [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_ra_data = r_regs[i_ra_addr];
    if (i_ra_addr == '0)                  o_ra_data = '0;
    else if (i_we && (i_wa == i_ra_addr)) o_ra_data = i_wd;
  end

  always_comb begin
    o_rb_data = r_regs[i_rb_addr];
    if (i_rb_addr == '0)                  o_rb_data = '0;
    else if (i_we && (i_wa == i_rb_addr)) o_rb_data = i_wd;
  end

endmodule

// File: rtl/instruction_decode.sv
// DLX ID stage: decode, register read, branch/jump resolution, load-use
// hazard stall and the ID/EX pipeline register.
module instruction_decode
  import dlx_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruc_reg,
  input  logic [PC_W-1:0]   PC_plus_1,
  input  logic              wb_write_en,
  input  logic [REG_AW-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt_addr,
  output logic              PC_sel,
  output logic [PC_W-1:0]   jump_address,
  output logic              stall,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  output logic [REG_AW-1:0] rd_addr,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_dst,
  output logic [3:0]        alu_op
);

  logic [5:0]        w_opcode_p0;
  logic [REG_AW-1:0] w_rs_p0, w_rt_p0, w_rd_p0;
  logic [DATA_W-1:0] w_rs_data_p0, w_rt_data_p0;
  logic [PC_W-1:0]   w_branch_tgt_p0;
  logic              w_hazard_p0;
  ctrl_t             w_ctrl_p0;

  assign w_opcode_p0 = instruc_reg[31:26];
  assign w_rs_p0     = instruc_reg[25:21];
  assign w_rt_p0     = instruc_reg[20:16];
  assign w_rd_p0     = instruc_reg[15:11];

  register_file u_regfile (
    .clock     (clock),
    .reset     (reset),
    .i_ra_addr (w_rs_p0),
    .i_rb_addr (w_rt_p0),
    .i_we      (wb_write_en),
    .i_wa      (wb_write_addr),
    .i_wd      (wb_write_data),
    .o_ra_data (w_rs_data_p0),
    .o_rb_data (w_rt_data_p0)
  );

  assign w_hazard_p0 = ex_mem_read && (ex_rt_addr != '0) &&
                       ((ex_rt_addr == w_rs_p0) || (ex_rt_addr == w_rt_p0));
  assign w_branch_tgt_p0 = PC_plus_1 + instruc_reg[PC_W-1:0];

  // Redirect is suppressed while stalled: the branch operands are not ready yet.
  always_comb begin
    stall        = 1'b0;
    PC_sel       = 1'b1;
    jump_address = w_branch_tgt_p0;
    if (!reset) begin
      stall = w_hazard_p0;
      if (!w_hazard_p0) begin
        case (w_opcode_p0)
          OP_BEQ: if (w_rs_data_p0 == w_rt_data_p0) PC_sel = 1'b0;
          OP_BNE: if (w_rs_data_p0 != w_rt_data_p0) PC_sel = 1'b0;
          OP_J: begin
            PC_sel       = 1'b0;
            jump_address = instruc_reg[PC_W-1:0];
          end
          default: PC_sel = 1'b1;
        endcase
      end
    end
  end

  assign w_ctrl_p0 = stall ? ctrl_t'('0) : decode_ctrl(w_opcode_p0, instruc_reg[5:0]);

  // ID/EX boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_data    <= '0;
      rt_data    <= '0;
      imm_ext    <= '0;
      rs_addr    <= '0;
      rt_addr    <= '0;
      rd_addr    <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_dst    <= 1'b0;
      alu_op     <= '0;
    end else begin
      rs_data    <= w_rs_data_p0;
      rt_data    <= w_rt_data_p0;
      imm_ext    <= {{16{instruc_reg[15]}}, instruc_reg[15:0]};
      rs_addr    <= w_rs_p0;
      rt_addr    <= w_rt_p0;
      rd_addr    <= w_rd_p0;
      reg_write  <= w_ctrl_p0.reg_write;
      mem_read   <= w_ctrl_p0.mem_read;
      mem_write  <= w_ctrl_p0.mem_write;
      alu_src    <= w_ctrl_p0.alu_src;
      mem_to_reg <= w_ctrl_p0.mem_to_reg;
      reg_dst    <= w_ctrl_p0.reg_dst;
      alu_op     <= w_ctrl_p0.alu_op;
    end
  end

endmodule
